prs_cpu_sequencer: RTL and testbench

PRS_CPU_SEQUENCER -- requirements
Module: prs_cpu_sequencer

---
 rtl/prs_cpu_pkg.sv | 46 ++++
 rtl/prs_wait_timer.sv | 29 ++
 rtl/prs_cpu_sequencer.sv | 137 +++++++++++++
 tb/tb_prs_cpu_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/prs_cpu_pkg.sv
// Shared encodings for the PRS CPU control sequencer: state codes, opcodes,
// ALU operation codes and the bundle of datapath control signals.
package prs_cpu_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DECODE  = 3'd2,
        S_OPFETCH = 3'd3,
        S_MEMOP   = 3'd4,
        S_EXEC    = 3'd5,
        S_HALT    = 3'd6,
        S_FAULT   = 3'd7
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_STA = 3'b100;
    localparam logic [2:0] OP_JMP = 3'b101;
    localparam logic [2:0] OP_JZ  = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    localparam logic [1:0] ALU_PASS = 2'b00;
    localparam logic [1:0] ALU_ADD  = 2'b01;
    localparam logic [1:0] ALU_SUB  = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       addr_sel;
        logic [1:0] alu_op;
        logic       pc_inc;
        logic       pc_load;
        logic       ir_load;
        logic       opr_load;
        logic       acc_load;
    } ctrl_t;

    // Instructions that need a second memory access through the operand address.
    function automatic logic needs_memop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_STA);
    endfunction

endpackage

// File: rtl/prs_wait_timer.sv
// Counts consecutive memory-wait cycles; expired flags the last allowed wait
// cycle so the sequencer can divert to FAULT on the following edge.
module prs_wait_timer #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count && !expired) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = (cnt == W'(TIMEOUT - 1));

endmodule

// File: rtl/prs_cpu_sequencer.sv
// Multi-cycle control sequencer for a small accumulator CPU: fetch, decode,
// operand fetch, memory operation and execute, with run/step and wait timeout.
module prs_cpu_sequencer
    import prs_cpu_pkg::*;
#(
    parameter int TIMEOUT = 15  // legal 1..255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       step,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       addr_sel,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       ir_load,
    output logic       opr_load,
    output logic       acc_load,
    output logic [1:0] alu_op,
    output logic       halted,
    output logic       fault,
    output logic [2:0] state
);

    state_t st, nxt;
    ctrl_t  ctrl;
    logic   step_q;
    logic   step_rise;
    logic   expired;
    state_t end_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st     <= S_IDLE;
            step_q <= 1'b0;
        end else begin
            st     <= nxt;
            step_q <= step;
        end
    end

    assign step_rise = step & ~step_q;
    assign end_next  = run ? S_FETCH : S_IDLE;

    // Any state change restarts the wait count, so each memory state starts at zero.
    prs_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait (
        .clk     (clk),
        .reset   (reset),
        .clear   (nxt != st),
        .count   (ctrl.mem_req & ~mem_ready),
        .expired (expired)
    );

    always_comb begin
        nxt  = st;
        ctrl = '0;
        case (st)
            S_IDLE: begin
                if (run || step_rise) nxt = S_FETCH;
            end
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                if (mem_ready) begin
                    ctrl.ir_load = 1'b1;
                    ctrl.pc_inc  = 1'b1;
                    nxt          = S_DECODE;
                end else if (expired) begin
                    nxt = S_FAULT;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_NOP:  nxt = S_EXEC;
                    OP_HLT:  nxt = S_HALT;
                    default: nxt = S_OPFETCH;
                endcase
            end
            S_OPFETCH: begin
                ctrl.mem_req = 1'b1;
                if (mem_ready) begin
                    ctrl.opr_load = 1'b1;
                    ctrl.pc_inc   = 1'b1;
                    nxt           = needs_memop(opcode) ? S_MEMOP : S_EXEC;
                end else if (expired) begin
                    nxt = S_FAULT;
                end
            end
            S_MEMOP: begin
                // Operand-addressed access; alu_op and mem_we are held for the whole wait.
                ctrl.mem_req  = 1'b1;
                ctrl.addr_sel = 1'b1;
                ctrl.mem_we   = (opcode == OP_STA);
                if (opcode == OP_ADD) ctrl.alu_op = ALU_ADD;
                if (opcode == OP_SUB) ctrl.alu_op = ALU_SUB;
                if (mem_ready) begin
                    ctrl.acc_load = (opcode == OP_ADD) || (opcode == OP_SUB);
                    nxt           = end_next;
                end else if (expired) begin
                    nxt = S_FAULT;
                end
            end
            S_EXEC: begin
                case (opcode)
                    OP_LDI: begin
                        ctrl.acc_load = 1'b1;
                        ctrl.alu_op   = ALU_PASS;
                    end
                    OP_JMP:  ctrl.pc_load = 1'b1;
                    OP_JZ:   ctrl.pc_load = zero;
                    default: ;
                endcase
                nxt = end_next;
            end
            S_HALT:  nxt = S_HALT;
            S_FAULT: nxt = S_FAULT;
            default: nxt = S_IDLE;
        endcase
    end

    assign mem_req  = ctrl.mem_req;
    assign mem_we   = ctrl.mem_we;
    assign addr_sel = ctrl.addr_sel;
    assign alu_op   = ctrl.alu_op;
    assign pc_inc   = ctrl.pc_inc;
    assign pc_load  = ctrl.pc_load;
    assign ir_load  = ctrl.ir_load;
    assign opr_load = ctrl.opr_load;
    assign acc_load = ctrl.acc_load;
    assign halted   = (st == S_HALT);
    assign fault    = (st == S_FAULT);
    assign state    = st;

endmodule

// File: tb/tb_prs_cpu_sequencer.sv
// Bench for prs_cpu_sequencer: vector table, directed corner sequences and a
// random instruction stream checked against an instruction-level expansion.
module tb_prs_cpu_sequencer;

    localparam int TO  = 15;
    localparam int NOP = 0, LDI = 1, ADD = 2, SUB = 3, STA = 4, JMP = 5, JZ = 6, HLT = 7;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0, step = 1'b0, zero = 1'b0, mem_ready = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       mem_req, mem_we, addr_sel, pc_inc, pc_load, ir_load, opr_load, acc_load;
    logic [1:0] alu_op;
    logic       halted, fault;
    logic [2:0] state;

    prs_cpu_sequencer #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .run(run), .step(step), .opcode(opcode),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .addr_sel(addr_sel), .pc_inc(pc_inc), .pc_load(pc_load), .ir_load(ir_load),
        .opr_load(opr_load), .acc_load(acc_load), .alu_op(alu_op), .halted(halted),
        .fault(fault), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       run, step;
        logic [2:0] op;
        logic       zero, rdy;
        logic [2:0] st;
        logic [9:0] sig;
    } vec_t;

    typedef struct {
        logic       run, rdy, zero;
        logic [2:0] op;
        logic [2:0] st;
        logic [9:0] sig;
    } exp_t;

    vec_t tbl[$];
    exp_t exp_q[$];
    logic [9:0] f_wait, f_done, o_wait, o_done, none;

    // sig order: mem_req, mem_we, addr_sel, alu_op[1:0], pc_inc, pc_load, ir_load, opr_load, acc_load
    function automatic logic [9:0] mk(int req, int we, int as, int alu, int pi, int pl,
                                      int ir, int opr, int acc);
        return {req[0], we[0], as[0], alu[1:0], pi[0], pl[0], ir[0], opr[0], acc[0]};
    endfunction

    task automatic chk_cycle(input string name, input logic [2:0] st, input logic [9:0] sig);
        logic [14:0] act, exp;
        act = {state, halted, fault, mem_req, mem_we, addr_sel, alu_op, pc_inc, pc_load,
               ir_load, opr_load, acc_load};
        exp = {st, st == 3'd6, st == 3'd7, sig};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t: got st/h/f/sig=%b required %b", name, $time, act, exp);
        end
    endtask

    task automatic drv(input int r, input int s, input int op, input int z, input int rd);
        @(negedge clk);
        run = r[0]; step = s[0]; opcode = op[2:0]; zero = z[0]; mem_ready = rd[0];
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        reset = 1'b1; run = 1'b0; step = 1'b0; mem_ready = 1'b0; opcode = 3'd0; zero = 1'b0;
        #1 chk_cycle("reset_held", 3'd0, none);
        @(negedge clk);
        reset = 1'b0;
        #1 chk_cycle("reset_release", 3'd0, none);
    endtask

    task automatic add(input int r, input int s, input int op, input int z, input int rd,
                       input int st, input logic [9:0] sig);
        vec_t v;
        v.run = r[0]; v.step = s[0]; v.op = op[2:0]; v.zero = z[0]; v.rdy = rd[0];
        v.st = st[2:0]; v.sig = sig;
        tbl.push_back(v);
    endtask

    task automatic push(input logic r, input logic rd, input int op, input logic z,
                        input int st, input logic [9:0] sig);
        exp_t e;
        e.run = r; e.rdy = rd; e.zero = z; e.op = op[2:0]; e.st = st[2:0]; e.sig = sig;
        exp_q.push_back(e);
    endtask

    // Expand one instruction into its expected cycle sequence with run held at 1
    // on the closing cycle and random noise on inputs that must be ignored.
    task automatic build(input int op, input logic z, input int w0, input int w1, input int w2);
        int alu;
        for (int i = 0; i < w0; i++) push(1'($urandom), 1'b0, op, z, 1, f_wait);
        push(1'($urandom), 1'b1, op, z, 1, f_done);
        push(1'($urandom), 1'($urandom), op, z, 2, none);
        if (op == NOP) begin
            push(1'b1, 1'($urandom), op, z, 5, none);
            return;
        end
        for (int i = 0; i < w1; i++) push(1'($urandom), 1'b0, op, z, 3, o_wait);
        push(1'($urandom), 1'b1, op, z, 3, o_done);
        if (op == ADD || op == SUB || op == STA) begin
            alu = (op == ADD) ? 1 : (op == SUB) ? 2 : 0;
            for (int i = 0; i < w2; i++)
                push(1'($urandom), 1'b0, op, z, 4, mk(1, op == STA, 1, alu, 0, 0, 0, 0, 0));
            push(1'b1, 1'b1, op, z, 4, mk(1, op == STA, 1, alu, 0, 0, 0, 0, op != STA));
        end else begin
            push(1'b1, 1'($urandom), op, z, 5,
                 mk(0, 0, 0, 0, 0, (op == JMP) || (op == JZ && z), 0, 0, op == LDI));
        end
    endtask

    function automatic int pick_wait();
        return ($urandom_range(0, 9) == 0) ? TO - 1 : int'($urandom_range(0, 4));
    endfunction

    initial begin
        int st_exp;
        f_wait = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        f_done = mk(1, 0, 0, 0, 1, 0, 1, 0, 0);
        o_wait = mk(1, 0, 0, 0, 0, 0, 0, 0, 0);
        o_done = mk(1, 0, 0, 0, 1, 0, 0, 1, 0);
        none   = '0;

        // run r, step s, op, zero, rdy -> state, strobes
        add(1, 0, LDI, 0, 1, 0, none);
        add(1, 0, LDI, 0, 1, 1, f_done);
        add(1, 0, LDI, 0, 1, 2, none);
        add(1, 0, LDI, 0, 1, 3, o_done);
        add(1, 0, LDI, 0, 1, 5, mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
        add(1, 0, JZ,  0, 1, 1, f_done);
        add(1, 0, JZ,  0, 1, 2, none);
        add(1, 0, JZ,  0, 1, 3, o_done);
        add(1, 0, JZ,  0, 1, 5, none);
        add(1, 0, JZ,  1, 1, 1, f_done);
        add(1, 0, JZ,  1, 1, 2, none);
        add(1, 0, JZ,  1, 1, 3, o_done);
        add(0, 0, JZ,  1, 1, 5, mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        add(0, 0, JZ,  1, 1, 0, none);
        add(0, 0, NOP, 0, 1, 0, none);
        add(1, 0, JMP, 0, 1, 0, none);
        add(1, 0, JMP, 0, 1, 1, f_done);
        add(1, 0, JMP, 0, 1, 2, none);
        add(1, 0, JMP, 0, 1, 3, o_done);
        add(0, 0, JMP, 0, 1, 5, mk(0, 0, 0, 0, 0, 1, 0, 0, 0));
        add(0, 0, JMP, 0, 1, 0, none);

        @(negedge clk);
        #1 chk_cycle("power_on_reset", 3'd0, none);
        do_reset;
        foreach (tbl[i]) begin
            drv(tbl[i].run, tbl[i].step, tbl[i].op, tbl[i].zero, tbl[i].rdy);
            chk_cycle($sformatf("vec%0d", i), tbl[i].st, tbl[i].sig);
        end

        // Reset asserted mid-FETCH drops mem_req without waiting for a clock edge.
        do_reset;
        drv(1, 0, NOP, 0, 0); chk_cycle("rst_pre_idle", 3'd0, none);
        drv(1, 0, NOP, 0, 0); chk_cycle("rst_pre_fetch", 3'd1, f_wait);
        #2 reset = 1'b1;
        #1 chk_cycle("rst_mid_fetch", 3'd0, none);
        @(negedge clk);
        reset = 1'b0; run = 1'b0;
        #1 chk_cycle("rst_after_release", 3'd0, none);
        drv(0, 0, NOP, 0, 1); chk_cycle("rst_idle_hold", 3'd0, none);

        // ADD with three wait cycles in MEMOP; run dropped mid-instruction.
        do_reset;
        drv(1, 0, ADD, 0, 1); chk_cycle("add_idle", 3'd0, none);
        drv(1, 0, ADD, 0, 1); chk_cycle("add_fetch", 3'd1, f_done);
        drv(0, 0, ADD, 0, 1); chk_cycle("add_decode", 3'd2, none);
        drv(0, 0, ADD, 0, 1); chk_cycle("add_opfetch", 3'd3, o_done);
        for (int i = 0; i < 4; i++) begin
            drv((i == 3) ? 0 : int'($urandom_range(0, 1)), 0, ADD, 0, (i == 3) ? 1 : 0);
            chk_cycle($sformatf("add_memop%0d", i), 3'd4, mk(1, 0, 1, 1, 0, 0, 0, 0, i == 3));
        end
        drv(0, 0, ADD, 0, 1); chk_cycle("add_end_idle", 3'd0, none);

        // step held high: one NOP, then a fresh edge starts the next instruction.
        do_reset;
        for (int i = 0; i < 10; i++) begin
            st_exp = (i == 1) ? 1 : (i == 2) ? 2 : (i == 3) ? 5 : 0;
            drv(0, 1, NOP, 0, 1);
            chk_cycle($sformatf("step_hold%0d", i), st_exp[2:0], (i == 1) ? f_done : none);
        end
        drv(0, 0, NOP, 0, 1); chk_cycle("step_low0", 3'd0, none);
        drv(0, 0, NOP, 0, 1); chk_cycle("step_low1", 3'd0, none);
        drv(0, 1, NOP, 0, 1); chk_cycle("step_edge2", 3'd0, none);
        drv(0, 1, NOP, 0, 1); chk_cycle("step_fetch2", 3'd1, f_done);

        // TIMEOUT-1 waits then ready: must not fault.
        do_reset;
        drv(1, 0, NOP, 0, 0); chk_cycle("edge_idle", 3'd0, none);
        for (int i = 0; i < TO; i++) begin
            drv(1, 0, NOP, 0, (i == TO - 1) ? 1 : 0);
            chk_cycle($sformatf("edge_fetch%0d", i), 3'd1, (i == TO - 1) ? f_done : f_wait);
        end
        drv(0, 0, NOP, 0, 0); chk_cycle("edge_decode", 3'd2, none);

        // TIMEOUT waits in FETCH: fault, then terminal.
        do_reset;
        drv(1, 0, NOP, 0, 0); chk_cycle("to_idle", 3'd0, none);
        for (int i = 0; i < TO; i++) begin
            drv(1, 0, NOP, 0, 0);
            chk_cycle($sformatf("to_fetch%0d", i), 3'd1, f_wait);
        end
        drv(1, 0, NOP, 0, 0); chk_cycle("to_fault", 3'd7, none);
        for (int i = 0; i < 6; i++) begin
            drv(i % 2, (i / 2) % 2, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1));
            chk_cycle($sformatf("fault_hold%0d", i), 3'd7, none);
        end

        // HLT: terminal halted state.
        do_reset;
        drv(1, 0, HLT, 0, 1); chk_cycle("hlt_idle", 3'd0, none);
        drv(1, 0, HLT, 0, 1); chk_cycle("hlt_fetch", 3'd1, f_done);
        drv(1, 0, HLT, 0, 1); chk_cycle("hlt_decode", 3'd2, none);
        drv(0, 0, HLT, 0, 1); chk_cycle("hlt_halt", 3'd6, none);
        for (int i = 0; i < 6; i++) begin
            drv((i + 1) % 2, i % 2, $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1));
            chk_cycle($sformatf("halt_hold%0d", i), 3'd6, none);
        end

        // Random free-running instruction stream.
        do_reset;
        drv(1, 0, NOP, 0, 1); chk_cycle("rand_idle", 3'd0, none);
        for (int n = 0; n < 40; n++)
            build($urandom_range(0, 6), 1'($urandom), pick_wait(), pick_wait(), pick_wait());
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            drv(e.run, $urandom_range(0, 1), e.op, e.zero, e.rdy);
            chk_cycle("rand_stream", e.st, e.sig);
        end
        do_reset;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
